// File: rtl/alu_md_unit.sv
// ALU with iterative shift-add multiply and restoring divide behind a valid/ready handshake.
// Single-cycle ops answer on the accept edge; MUL/MULHU/DIVU/REMU take WIDTH more edges.
module alu_md_unit #(
  parameter int WIDTH = 32,
  parameter bit MD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control_i,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_o,
  output logic             zero,
  output logic             overflow,
  output logic             carry,
  output logic             negative,
  output logic             busy
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_hi;
  logic [WIDTH-1:0]       r_mcand;
  logic [2*WIDTH-1:0]     r_prod;
  logic [WIDTH-1:0]       r_dvs;
  logic [WIDTH-1:0]       r_rem;
  logic [WIDTH-1:0]       r_quo;

  logic                   r_valid;
  logic [WIDTH-1:0]       r_alu;
  logic                   r_zero;
  logic                   r_ovf;
  logic                   r_carry;
  logic                   r_neg;

  logic                   w_accept;
  logic                   w_is_mul;
  logic                   w_is_div;
  logic                   w_single;
  logic                   w_last;
  logic                   w_md_done;
  logic [SH_W-1:0]        w_shamt;
  logic [WIDTH:0]         w_sum;
  logic [WIDTH:0]         w_diff;
  logic [WIDTH-1:0]       w_res;
  logic                   w_c;
  logic                   w_v;
  logic [WIDTH:0]         w_acc;
  logic [2*WIDTH-1:0]     w_prod_nxt;
  logic [WIDTH:0]         w_shifted;
  logic [WIDTH:0]         w_trial;
  logic [WIDTH-1:0]       w_rem_nxt;
  logic [WIDTH-1:0]       w_quo_nxt;
  logic [WIDTH-1:0]       w_md_res;

  assign w_accept  = in_valid && in_ready;
  assign w_is_mul  = MD_EN && ((control_i == OP_MUL) || (control_i == OP_MULHU));
  assign w_is_div  = MD_EN && ((control_i == OP_DIVU) || (control_i == OP_REMU)) && (in2 != '0);
  assign w_single  = !(w_is_mul || w_is_div);
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_md_done = (r_state != S_IDLE) && w_last;
  assign w_shamt   = in2[SH_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
        else if (w_accept && w_is_div) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    in_ready = (r_state == S_IDLE) && (!r_valid || out_ready);
  end

  // Single-cycle result; the zero-divisor cases of DIVU/REMU are resolved here too.
  always_comb begin
    w_sum  = {1'b0, in1} + {1'b0, in2};
    w_diff = {1'b0, in1} - {1'b0, in2};
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (control_i)
      OP_AND:  w_res = in1 & in2;
      OP_OR:   w_res = in1 | in2;
      OP_XOR:  w_res = in1 ^ in2;
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = ~w_diff[WIDTH];
        w_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLL:  w_res = in1 << w_shamt;
      OP_SRL:  w_res = in1 >> w_shamt;
      OP_SRA:  w_res = WIDTH'($signed(in1) >>> w_shamt);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_DIVU: if (MD_EN && (in2 == '0)) w_res = '1;
      OP_REMU: if (MD_EN && (in2 == '0)) w_res = in1;
      default: w_res = '0;
    endcase
  end

  // One multiplier bit and one quotient bit retire per busy cycle.
  always_comb begin
    w_acc      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    w_prod_nxt = {w_acc, r_prod[WIDTH-1:1]};
    w_shifted  = {r_rem, r_quo[WIDTH-1]};
    w_trial    = w_shifted - {1'b0, r_dvs};
    w_rem_nxt  = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_quo_nxt  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
    if (r_state == S_MUL) w_md_res = r_hi ? w_prod_nxt[2*WIDTH-1:WIDTH] : w_prod_nxt[WIDTH-1:0];
    else                  w_md_res = r_hi ? w_rem_nxt : w_quo_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_hi    <= 1'b0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_hi    <= (control_i == OP_MULHU) || (control_i == OP_REMU);
      r_mcand <= in1;
      r_prod  <= {{WIDTH{1'b0}}, in2};
      r_dvs   <= in2;
      r_rem   <= '0;
      r_quo   <= in1;
    end else if (r_state == S_MUL) begin
      r_prod  <= w_prod_nxt;
      r_cnt   <= r_cnt + CNT_W'(1);
    end else if (r_state == S_DIV) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_neg   <= 1'b0;
    end else if (w_accept && w_single) begin
      r_valid <= 1'b1;
      r_alu   <= w_res;
      r_zero  <= (w_res == '0);
      r_ovf   <= w_v;
      r_carry <= w_c;
      r_neg   <= w_res[WIDTH-1];
    end else if (w_md_done) begin
      r_valid <= 1'b1;
      r_alu   <= w_md_res;
      r_zero  <= (w_md_res == '0);
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_neg   <= w_md_res[WIDTH-1];
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign ALU_o     = r_alu;
  assign zero      = r_zero;
  assign overflow  = r_ovf;
  assign carry     = r_carry;
  assign negative  = r_neg;

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_md_unit;

  localparam int W = 32;
  localparam longint MAXS = 64'sh7FFFFFFF;
  localparam longint MINS = -64'sh80000000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   control_i;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALU_o;
  logic         zero;
  logic         overflow;
  logic         carry;
  logic         negative;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         v;
    logic         c;
    logic         n;
    int           lat;
  } exp_t;

  alu_md_unit #(.WIDTH(W), .MD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .control_i(control_i), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_o(ALU_o), .zero(zero), .overflow(overflow),
    .carry(carry), .negative(negative), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    longint       sa;
    longint       sb;
    longint       s;
    logic [63:0]  t;
    sa    = $signed(a);
    sb    = $signed(b);
    e.res = '0;
    e.v   = 1'b0;
    e.c   = 1'b0;
    e.lat = 1;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2: begin
        t     = 64'(a) + 64'(b);
        e.res = t[W-1:0];
        e.c   = t[W];
        s     = sa + sb;
        e.v   = (s > MAXS) || (s < MINS);
      end
      4'd3:  e.res = a << b[4:0];
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = a >> b[4:0];
      4'd6: begin
        e.res = a - b;
        e.c   = (a >= b);
        s     = sa - sb;
        e.v   = (s > MAXS) || (s < MINS);
      end
      4'd7: begin
        s     = sa >>> b[4:0];
        e.res = s[W-1:0];
      end
      4'd8:  e.res = (sa < sb) ? 1 : 0;
      4'd9:  e.res = (a < b) ? 1 : 0;
      4'd10: begin t = 64'(a) * 64'(b); e.res = t[W-1:0];  e.lat = W + 1; end
      4'd11: begin t = 64'(a) * 64'(b); e.res = t[63:W];   e.lat = W + 1; end
      4'd12: if (b == 0) e.res = '1; else begin e.res = a / b; e.lat = W + 1; end
      4'd13: if (b == 0) e.res = a;  else begin e.res = a % b; e.lat = W + 1; end
      default: e.res = '0;
    endcase
    e.z = (e.res == 0);
    e.n = e.res[W-1];
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkResult(input string tag, input exp_t e);
    checkOutput({tag, "_res"}, ALU_o, e.res);
    checkOutput({tag, "_zero"}, zero, e.z);
    checkOutput({tag, "_ovf"}, overflow, e.v);
    checkOutput({tag, "_carry"}, carry, e.c);
    checkOutput({tag, "_neg"}, negative, e.n);
  endtask

  task automatic waitReady(input string tag);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput({tag, "_ready"}, in_ready, 1);
  endtask

  // Issue one op, hold garbage on the inputs while it runs, check latency/result, then consume it.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    exp_t e;
    int   lat;
    int   busyCyc;
    int   readyHigh;
    e = refModel(op, a, b);
    waitReady(tag);
    in_valid  = 1'b1;
    control_i = op;
    in1       = a;
    in2       = b;
    @(posedge clk); #1;
    control_i = 4'($urandom);
    in1       = $urandom;
    in2       = $urandom;
    lat       = 1;
    busyCyc   = 0;
    readyHigh = 0;
    while (!out_valid && lat < 200) begin
      if (busy)     busyCyc++;
      if (in_ready) readyHigh++;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_lat"}, lat, e.lat);
    checkOutput({tag, "_busycyc"}, busyCyc, e.lat - 1);
    checkOutput({tag, "_readyhigh"}, readyHigh, 0);
    checkResult(tag, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_consumed"}, out_valid, 0);
  endtask

  initial begin
    exp_t         e;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           stale;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    control_i = 4'd0;
    in1       = '0;
    in2       = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_alu", ALU_o, 0);
    checkOutput("rst_zero", zero, 0);
    checkOutput("rst_ovf", overflow, 0);
    checkOutput("rst_carry", carry, 0);
    checkOutput("rst_neg", negative, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    checkOutput("rst_inready", in_ready, 1);

    applyStimulus(4'd2, 32'h7FFFFFFF, 32'h00000001, "add_ovf");
    applyStimulus(4'd6, 32'd5, 32'd5, "sub_eq");
    applyStimulus(4'd7, 32'h80000000, 32'd4, "sra");
    applyStimulus(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max");
    applyStimulus(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul_max");
    applyStimulus(4'd12, 32'd100, 32'd7, "divu");
    applyStimulus(4'd13, 32'd100, 32'd7, "remu");
    applyStimulus(4'd12, 32'd100, 32'd0, "divu_zero");
    applyStimulus(4'd13, 32'd100, 32'd0, "remu_zero");
    applyStimulus(4'd8, 32'hFFFFFFFF, 32'd1, "slt_neg");
    applyStimulus(4'd9, 32'hFFFFFFFF, 32'd1, "sltu");
    applyStimulus(4'd15, 32'h1234, 32'h5678, "illegal");

    // Backpressure: result must hold while new requests are refused.
    waitReady("bp");
    a = $urandom; b = $urandom;
    e = refModel(4'd4, a, b);
    in_valid = 1'b1; control_i = 4'd4; in1 = a; in2 = b;
    @(posedge clk); #1;
    control_i = 4'd2; in1 = $urandom; in2 = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_inready", in_ready, 0);
      checkResult("bp", e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_drain", out_valid, 0);

    // Back-to-back single-cycle ops with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = 4'($urandom_range(0, 9));
      a  = $urandom; b = $urandom;
      e  = refModel(op, a, b);
      in_valid = 1'b1; control_i = op; in1 = a; in2 = b;
      @(posedge clk); #1;
      checkOutput("b2b_valid", out_valid, 1);
      checkResult("b2b", e);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b_drain", out_valid, 0);
    out_ready = 1'b0;

    // Reset in the middle of a divide must leave no trace of it.
    waitReady("rstdiv");
    in_valid = 1'b1; control_i = 4'd12; in1 = 32'd100; in2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("rstdiv_busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstdiv_valid", out_valid, 0);
    checkOutput("rstdiv_busy", busy, 0);
    checkOutput("rstdiv_alu", ALU_o, 0);
    rst_n = 1'b1;
    checkOutput("rstdiv_inready", in_ready, 1);
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checkOutput("rstdiv_stale", stale, 0);

    // Random ops with occasional small/zero divisors and edge operands.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 3);
        1:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      applyStimulus(op, a, b, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_md_unit.md
ALU_MD_UNIT -- requirements
Module: alu_md_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have parameter MD_EN, default 1, meaning multiply/divide ops are enabled; when 0 those ops are illegal.
REQ-003 clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 control_i  input  4  operation select.
REQ-008 in1, in2  input  WIDTH  operands.
REQ-009 out_valid  output  1  result registers hold an unconsumed result.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 ALU_o  output  WIDTH  result.
REQ-012 zero, overflow, carry, negative  output  1 each  flags qualified by out_valid.
REQ-013 busy  output  1  high in MUL or DIV state.

Function
REQ-014 Op encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 XOR, 0101 SRL, 0110 SUB, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1101 REMU; all others are illegal.
REQ-015 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; operands and op SHALL be captured on that edge.
REQ-016 in_ready SHALL be 1 only in IDLE and when out_valid is 0 or out_ready is 1 in the same cycle.
REQ-017 The FSM SHALL have states IDLE, MUL, DIV; IDLE->MUL on accepting MUL/MULHU, IDLE->DIV on accepting DIVU/REMU with nonzero in2, MUL/DIV->IDLE on the edge that loads the result.
REQ-018 Single-cycle ops (AND..SLTU, illegal ops, DIVU/REMU with in2==0) SHALL load the result registers on the accept edge, giving out_valid 1 cycle after acceptance.
REQ-019 MUL/MULHU SHALL use an iterative shift-add over 2*WIDTH-bit product, one bit per cycle, and DIVU/REMU SHALL use restoring division, one quotient bit per cycle.
REQ-020 Multi-cycle ops SHALL perform exactly WIDTH iterations and load the result on the edge completing the last one, giving out_valid WIDTH+1 cycles after acceptance.
REQ-021 Shift amount SHALL be in2[log2(WIDTH)-1:0]; SRA SHALL replicate in1[WIDTH-1].
REQ-022 SLT/SLTU SHALL return 1 or 0 zero-extended to WIDTH, signed and unsigned compare respectively.
REQ-023 ADD carry SHALL be bit WIDTH of the (WIDTH+1)-bit sum; SUB carry SHALL be the inverse of the borrow (1 when in1>=in2 unsigned).
REQ-024 overflow SHALL be set for ADD when operand signs match and result sign differs, for SUB when operand signs differ and result sign differs from in1; carry and overflow SHALL be 0 for all other ops.
REQ-025 zero SHALL be 1 when ALU_o is all zeros; negative SHALL equal ALU_o[WIDTH-1]; both are computed for every op.
REQ-026 DIVU by zero SHALL return all ones; REMU by zero SHALL return in1.
REQ-027 Illegal ops, including MUL..REMU when MD_EN=0, SHALL return 0 with zero=1 and all other flags 0.
REQ-028 Result and flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 out_valid SHALL clear on an edge with out_ready=1 unless a new single-cycle result loads on that same edge, in which case it stays 1 with new data.
REQ-030 in_valid during MUL/DIV SHALL be ignored (in_ready=0) and SHALL NOT disturb the iteration.

Reset
REQ-031 On a rising edge with rst_n=0 the FSM SHALL go to IDLE, iteration counter clear, out_valid=0, ALU_o=0, all flags 0, busy=0; in_ready=1 in the first cycle after reset deasserts.
REQ-032 Reset asserted mid MUL/DIV SHALL abort the operation with no result produced.

Verification
REQ-033 ADD 0x7FFFFFFF+0x00000001 -> ALU_o=0x80000000, overflow=1, negative=1, carry=0, zero=0, out_valid 1 cycle after accept.
REQ-034 SUB 5-5 -> ALU_o=0, zero=1, carry=1, overflow=0; SRA 0x80000000 by 4 -> 0xF8000000, negative=1.
REQ-035 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001; out_valid exactly 33 cycles after accept, busy=1 for 32 cycles, in_ready=0 throughout.
REQ-036 DIVU 100/7 -> 14, REMU 100/7 -> 2 in 33 cycles; DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100 in 1 cycle.
REQ-037 Backpressure: result held 5 cycles with out_ready=0 -> ALU_o/flags unchanged, in_ready=0; back-to-back single-cycle ops with out_ready=1 -> one result per cycle.
REQ-038 rst_n low on cycle 10 of a DIVU -> next cycle out_valid=0, busy=0, ALU_o=0; in_ready=1 once rst_n high, no stale result ever appears.
